// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: default widths and FSM state encoding.
package load_store_unit_pkg;

    localparam int LSU_ADDR_W = 6;
    localparam int LSU_DATA_W = 16;
    localparam int LSU_LEN_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD     = 2'd1,
        WR     = 2'd2,
        WFLUSH = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request / store-data / load-response handshake bundle of the load/store unit.
interface load_store_unit_if
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W,
    parameter int LEN_W  = LSU_LEN_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              wr_done;

    // Core (execute stage) side
    modport master (
        output req_valid, req_we, req_addr, req_len, wdata_valid, wdata, resp_ready,
        input  req_ready, wdata_ready, resp_valid, resp_rdata, wr_done
    );

    // Load/store unit side
    modport slave (
        input  req_valid, req_we, req_addr, req_len, wdata_valid, wdata, resp_ready,
        output req_ready, wdata_ready, resp_valid, resp_rdata, wr_done
    );

endinterface

// File: rtl/lsu_resp_reg.sv
// Single-entry load output register: holds one word until the core accepts it.
module lsu_resp_reg
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              resp_ready,
    output logic              can_load,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata
);

    // A new word may enter when the slot is empty or is being drained this cycle.
    assign can_load = !resp_valid || resp_ready;

    // Capture a new word, or clear the slot once its word has been accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else if (load) begin
            resp_valid <= 1'b1;
            resp_rdata <= din;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sole master of the 64x16 data memory, streaming burst loads
// and stores between the core and the memory at one word per cycle.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W,
    parameter int LEN_W  = LSU_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus,
    output logic              mem_clock_enable,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    // Burst word counter needs one extra bit to hold len+1 (up to 8).
    localparam int REM_W = LEN_W + 1;

    lsu_state_e        state;
    lsu_state_e        next_state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] cur_addr_d;
    logic [REM_W-1:0]  remaining;
    logic [REM_W-1:0]  remaining_d;
    logic              read_enable_d;
    logic [ADDR_W-1:0] read_address_d;
    logic              write_enable_d;
    logic [ADDR_W-1:0] write_address_d;
    logic [DATA_W-1:0] data_in_d;
    logic              wr_done_d;
    logic              capture;
    logic              can_capture;
    logic              resp_valid;

    lsu_resp_reg #(
        .DATA_W (DATA_W)
    ) u_resp_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (capture),
        .din        (mem_data_out),
        .resp_ready (bus.resp_ready),
        .can_load   (can_capture),
        .resp_valid (resp_valid),
        .resp_rdata (bus.resp_rdata)
    );

    // mem_clock_enable doubles as "out of reset" so req_ready stays low while rst_n is low.
    assign bus.req_ready   = mem_clock_enable && (state == IDLE) && !resp_valid;
    assign bus.wdata_ready = (state == WR);
    assign bus.resp_valid  = resp_valid;

    // Next-state and next values of every registered memory-side output.
    always_comb begin
        next_state      = state;
        cur_addr_d      = cur_addr;
        remaining_d     = remaining;
        read_enable_d   = mem_read_enable;
        read_address_d  = mem_read_address;
        write_enable_d  = 1'b0;
        write_address_d = mem_write_address;
        data_in_d       = mem_data_in;
        wr_done_d       = 1'b0;
        capture         = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    cur_addr_d  = bus.req_addr;
                    remaining_d = REM_W'(bus.req_len) + REM_W'(1);
                    if (bus.req_we) begin
                        next_state = WR;
                    end else begin
                        next_state     = RD;
                        read_enable_d  = 1'b1;
                        read_address_d = bus.req_addr;
                    end
                end
            end
            RD: begin
                capture = can_capture;
                if (capture) begin
                    cur_addr_d     = cur_addr + ADDR_W'(1);
                    read_address_d = cur_addr + ADDR_W'(1);
                    remaining_d    = remaining - REM_W'(1);
                    if (remaining == REM_W'(1)) begin
                        next_state    = IDLE;
                        read_enable_d = 1'b0;
                    end
                end
            end
            WR: begin
                if (bus.wdata_valid) begin
                    write_enable_d  = 1'b1;
                    write_address_d = cur_addr;
                    data_in_d       = bus.wdata;
                    cur_addr_d      = cur_addr + ADDR_W'(1);
                    remaining_d     = remaining - REM_W'(1);
                    if (remaining == REM_W'(1)) begin
                        next_state = WFLUSH;
                    end
                end
            end
            WFLUSH: begin
                // The last write commits on this cycle's closing edge; report it next cycle.
                wr_done_d  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State and all memory-side outputs are flops so the write strobe is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cur_addr          <= '0;
            remaining         <= '0;
            mem_clock_enable  <= 1'b0;
            mem_read_enable   <= 1'b0;
            mem_read_address  <= '0;
            mem_write_enable  <= 1'b0;
            mem_write_address <= '0;
            mem_data_in       <= '0;
            bus.wr_done       <= 1'b0;
        end else begin
            state             <= next_state;
            cur_addr          <= cur_addr_d;
            remaining         <= remaining_d;
            mem_clock_enable  <= 1'b1;
            mem_read_enable   <= read_enable_d;
            mem_read_address  <= read_address_d;
            mem_write_enable  <= write_enable_d;
            mem_write_address <= write_address_d;
            mem_data_in       <= data_in_d;
            bus.wr_done       <= wr_done_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data memory and a
// word-array reference model of memory contents.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_clock_enable;
    logic        mem_read_enable;
    logic [5:0]  mem_read_address;
    logic        mem_write_enable;
    logic [5:0]  mem_write_address;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus),
        .mem_clock_enable  (mem_clock_enable),
        .mem_read_enable   (mem_read_enable),
        .mem_read_address  (mem_read_address),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .mem_data_in       (mem_data_in),
        .mem_data_out      (mem_data_out)
    );

    // Data memory: synchronous write, combinational read
    logic [15:0] mem [64];
    always @(posedge clk) begin
        if (mem_clock_enable && mem_write_enable) mem[mem_write_address] <= mem_data_in;
    end
    assign mem_data_out = mem[mem_read_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model and bookkeeping
    logic [15:0] ref_mem [64];
    logic [15:0] wbuf [8];
    int checks   = 0;
    int failures = 0;

    int          cyc = 0;
    int          stab_err = 0;
    int          overlap = 0;
    logic        hold_pending = 1'b0;
    logic [15:0] held = '0;
    logic [15:0] got_q [$];
    int          got_cyc_q [$];
    logic [5:0]  wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int          wr_cyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe handshakes, writes and hold stability mid-cycle
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid && bus.resp_ready) begin
            got_q.push_back(bus.resp_rdata);
            got_cyc_q.push_back(cyc);
        end
        if (mem_write_enable) begin
            wr_addr_q.push_back(mem_write_address);
            wr_data_q.push_back(mem_data_in);
            wr_cyc_q.push_back(cyc);
        end
        if (mem_read_enable && mem_write_enable) overlap <= overlap + 1;
        if (!rst_n) begin
            hold_pending <= 1'b0;
        end else begin
            if (hold_pending && !(bus.resp_valid && bus.resp_rdata == held)) stab_err <= stab_err + 1;
            hold_pending <= bus.resp_valid && !bus.resp_ready;
            held         <= bus.resp_rdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_ready(input string tag);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_req_ready"}, 32'(bus.req_ready), 1);
    endtask

    task automatic do_store(input logic [5:0] a, input logic [2:0] l, input int stall_at,
                            input int stall_n, input bit gaps, input string tag);
        int n;
        int w0;
        int c;
        int idx;
        n  = int'(l) + 1;
        w0 = wr_addr_q.size();
        wait_req_ready(tag);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_len   = l;
        step();
        bus.req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            c = (i == stall_at) ? stall_n : (gaps ? int'($urandom_range(0, 2)) : 0);
            bus.wdata_valid = 1'b0;
            for (int k = 0; k < c; k++) begin
                step();
                if (i == stall_at) check({tag, "_gap_we"}, 32'(mem_write_enable), 0);
            end
            check({tag, "_wready"}, 32'(bus.wdata_ready), 1);
            bus.wdata_valid = 1'b1;
            bus.wdata       = wbuf[i];
            step();
        end
        bus.wdata_valid = 1'b0;
        check({tag, "_done_early"}, 32'(bus.wr_done), 0);
        step();
        check({tag, "_done"}, 32'(bus.wr_done), 1);
        for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 64] = wbuf[i];
        check({tag, "_nwrites"}, 32'(wr_addr_q.size() - w0), 32'(n));
        for (int i = 0; i < n && (w0 + i) < wr_addr_q.size(); i++) begin
            idx = (int'(a) + i) % 64;
            check($sformatf("%s_waddr%0d", tag, i), 32'(wr_addr_q[w0 + i]), 32'(idx));
            check($sformatf("%s_wdata%0d", tag, i), 32'(wr_data_q[w0 + i]), 32'(wbuf[i]));
            check($sformatf("%s_mem%0d", tag, idx), 32'(mem[idx]), 32'(ref_mem[idx]));
        end
        if (!gaps && stall_at < 0 && (wr_cyc_q.size() - w0) == n)
            check({tag, "_wspan"}, 32'(wr_cyc_q[w0 + n - 1] - wr_cyc_q[w0]), 32'(n - 1));
        step();
        check({tag, "_done_pulse"}, 32'(bus.wr_done), 0);
    endtask

    // mode 0: resp_ready held 1; mode 1: pattern 1,0,0; mode 2: random
    task automatic do_load(input logic [5:0] a, input logic [2:0] l, input int mode, input string tag);
        int n;
        int g0;
        int s0;
        int k;
        logic [15:0] exp_q [$];
        n = int'(l) + 1;
        for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(int'(a) + i) % 64]);
        wait_req_ready(tag);
        g0 = got_q.size();
        s0 = stab_err;
        bus.resp_ready = (mode == 0);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = a;
        bus.req_len    = l;
        step();
        bus.req_valid = 1'b0;
        if (mode == 0) begin
            check({tag, "_lat1_valid"}, 32'(bus.resp_valid), 0);
            step();
            check({tag, "_lat2_valid"}, 32'(bus.resp_valid), 1);
            check({tag, "_lat2_data"}, 32'(bus.resp_rdata), 32'(exp_q[0]));
        end
        k = 0;
        while (!((got_q.size() - g0) == n && !bus.resp_valid) && k < 200) begin
            if (mode == 1) bus.resp_ready = (k % 3 == 0);
            else if (mode == 2) bus.resp_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        check({tag, "_timeout"}, 32'(k < 200), 1);
        check({tag, "_count"}, 32'(got_q.size() - g0), 32'(n));
        for (int i = 0; i < n && (g0 + i) < got_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 32'(got_q[g0 + i]), 32'(exp_q[i]));
        check({tag, "_stable"}, 32'(stab_err - s0), 0);
        if (mode == 0) begin
            if ((got_q.size() - g0) == n)
                check({tag, "_span"}, 32'(got_cyc_q[g0 + n - 1] - got_cyc_q[g0]), 32'(n - 1));
            check({tag, "_req_ready_after"}, 32'(bus.req_ready), 1);
        end
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ra;
        logic [2:0] rl;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.req_addr    = '0;
        bus.req_len     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.resp_ready  = 1'b0;
        step();
        step();

        // Reset state
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_wdata_ready", 32'(bus.wdata_ready), 0);
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_resp_rdata", 32'(bus.resp_rdata), 0);
        check("rst_wr_done", 32'(bus.wr_done), 0);
        check("rst_clk_en", 32'(mem_clock_enable), 0);
        check("rst_read_en", 32'(mem_read_enable), 0);
        check("rst_write_en", 32'(mem_write_enable), 0);
        check("rst_read_addr", 32'(mem_read_address), 0);
        check("rst_write_addr", 32'(mem_write_address), 0);
        check("rst_data_in", 32'(mem_data_in), 0);
        rst_n = 1'b1;
        step();
        check("post_rst_clk_en", 32'(mem_clock_enable), 1);
        check("post_rst_req_ready", 32'(bus.req_ready), 1);

        // Back-to-back store then full-rate load
        for (int i = 0; i < 4; i++) wbuf[i] = 16'hA001 + 16'(i);
        do_store(6'd5, 3'd3, -1, 0, 1'b0, "st5");
        do_load(6'd5, 3'd3, 0, "ld5");

        // Address wrap 62 -> 1
        for (int i = 0; i < 4; i++) wbuf[i] = 16'(i + 1);
        do_store(6'd62, 3'd3, -1, 0, 1'b0, "st_wrap");
        do_load(6'd62, 3'd3, 0, "ld_wrap");

        // Store stall mid-burst, then load under 1,0,0 backpressure
        for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
        do_store(6'd30, 3'd7, 4, 3, 1'b0, "st_stall");
        do_load(6'd30, 3'd7, 1, "ld_bp");

        // Reset mid-store: two words committed, third abandoned
        for (int i = 0; i < 4; i++) wbuf[i] = 16'hB001 + 16'(i);
        wait_req_ready("rst_st");
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 6'd5;
        bus.req_len   = 3'd3;
        step();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wdata_valid = 1'b1;
            bus.wdata       = wbuf[i];
            step();
        end
        rst_n = 1'b0;
        #1;
        check("midrst_write_en", 32'(mem_write_enable), 0);
        check("midrst_wdata_ready", 32'(bus.wdata_ready), 0);
        check("midrst_req_ready", 32'(bus.req_ready), 0);
        check("midrst_clk_en", 32'(mem_clock_enable), 0);
        bus.wdata_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("midrst_release_req_ready", 32'(bus.req_ready), 1);
        ref_mem[5] = 16'hB001;
        ref_mem[6] = 16'hB002;
        check("midrst_mem7_kept", 32'(mem[7]), 32'(ref_mem[7]));
        do_load(6'd5, 3'd3, 2, "ld_after_rst");

        // Randomized bursts against the reference memory
        for (int it = 0; it < 6; it++) begin
            ra = 6'($urandom);
            rl = 3'($urandom);
            for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
            do_store(ra, rl, -1, 0, 1'b1, $sformatf("rnd_st%0d", it));
            do_load(ra, rl, 2, $sformatf("rnd_ld%0d", it));
        end

        check("no_rw_overlap", 32'(overlap), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port: accepts burst load/store requests from the core over a valid/ready handshake.
- Drives the 64x16 data memory's read and write ports.
- Streams store data in and load data out, one word per cycle at full throughput.
- Sits between the execute stage and data_memory; it is the only master of that memory.

Parameters:
- ADDR_W, 6, word-address width; the memory depth is 2**ADDR_W.
- DATA_W, 16, word width.
- LEN_W, 3, burst-length field width; a burst is req_len+1 words (1..8).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store burst, 0 = load burst.
- req_addr  in  ADDR_W  start word address.
- req_len  in  LEN_W  burst length minus one.
- wdata_valid  in  1  store data word valid.
- wdata_ready  out  1  unit accepts a store word.
- wdata  in  DATA_W  store data.
- resp_valid  out  1  load data word valid.
- resp_ready  in  1  core accepts a load word.
- resp_rdata  out  DATA_W  load data.
- wr_done  out  1  one-cycle pulse when the last store word has committed.
- mem_clock_enable  out  1  to memory clock_enable.
- mem_read_enable  out  1  to memory read_enable.
- mem_read_address  out  ADDR_W  to memory read_address.
- mem_write_enable  out  1  to memory write_enable.
- mem_write_address  out  ADDR_W  to memory write_address.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_data_out  in  DATA_W  from memory data_out (combinational read).

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - These outputs go to 0: req_ready, wdata_ready, resp_valid, resp_rdata, wr_done, mem_read_enable, mem_write_enable, all addresses, mem_data_in, mem_clock_enable.
  - A burst in progress is abandoned; no partial write may commit after reset asserts.
- After reset: mem_clock_enable is registered 1 from the first clock edge onward.
- All mem_* outputs come straight from flops. The memory's write strobe is gated by write_enable, so glitch-free enables are mandatory.
- State machine IDLE / RD / WR / WFLUSH:
  - IDLE:
    - req_ready = !resp_valid.
    - On req_valid && req_ready: latch req_addr as cur_addr and req_len+1 as remaining. Go to RD if req_we=0, else WR.
  - RD:
    - mem_read_enable = 1 and mem_read_address = cur_addr, both registered and set on entry.
    - A capture happens when the output register is empty or resp_ready=1. On a capture:
      - resp_rdata <= mem_data_out, resp_valid <= 1.
      - cur_addr increments and mem_read_address follows the same edge.
      - remaining decrements.
    - On the capture where remaining==1: go to IDLE and drop mem_read_enable. resp_valid holds until accepted.
    - When resp_valid && resp_ready and no new capture: resp_valid <= 0.
    - Throughput: one word per cycle when resp_ready is held high. First word is valid 2 cycles after the request handshake.
  - WR:
    - wdata_ready = 1.
    - On wdata_valid: register mem_write_address <= cur_addr, mem_data_in <= wdata, mem_write_enable <= 1. Then cur_addr increments and remaining decrements.
    - A word handshaked in cycle N commits to memory at the edge ending cycle N+1.
    - Without wdata_valid: mem_write_enable <= 0.
    - On the last word: go to WFLUSH with wdata_ready=0.
  - WFLUSH:
    - The final write commits; mem_write_enable <= 0.
    - wr_done pulses in the cycle following the commit edge.
    - Go to IDLE.
    - A load issued immediately after wr_done therefore sees the stored data; no read-after-write hazard.
- Address arithmetic is modulo 2**ADDR_W: address 63 increments to 0 within a burst.
- mem_read_enable and mem_write_enable are never high in the same cycle.
- req_ready = 0 in every state except IDLE.
- wdata_ready = 0 outside WR. wdata_valid outside WR is ignored.

Decomposition:
- Shared package holds:
  - ADDR_W, DATA_W, LEN_W defaults.
  - State encoding constants: IDLE=2'd0, RD=2'd1, WR=2'd2, WFLUSH=2'd3.
- One natural sub-module, lsu_resp_reg: the single-entry load output register with its valid/ready logic.

Test Plan:
- Store burst: addr=5, len=3, words 0xA001..0xA004 back-to-back -> mem_write_enable high 4 consecutive cycles, addrs 5..8, wr_done 2 cycles after the last handshake; memory[5..8] matches.
- Load burst with resp_ready held 1: addr=5, len=3 -> resp_rdata 0xA001..0xA004 on 4 consecutive cycles, the first 2 cycles after the handshake; req_ready returns 1 after the last word is accepted.
- Wrap: store addr=62, len=3, data 1..4 -> memory[62]=1, [63]=2, [0]=3, [1]=4; a load back of the same burst returns 1..4.
- Backpressure: load len=7 with resp_ready toggling 1,0,0,1,… -> no word dropped or duplicated; resp_rdata stable while resp_valid && !resp_ready.
- Store stall: wdata_valid low for 3 cycles mid-burst -> mem_write_enable low during the gap and only 8 writes occur; memory contents are correct.
- Reset mid-store: rst_n low after 2 of 4 words -> mem_write_enable 0 immediately, only the first 2 words are committed (checked via the load that follows reset), and req_ready = 1 the cycle after release.
